// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver, LSB first.
//
// Synchronises the asynchronous RX line, arms on a falling edge, confirms the
// start bit at its centre, samples each data bit at mid-bit, checks the stop
// bit and then presents the byte together with a one-clock valid strobe.
//
// Ports:
//   clk          in   system clock, rising edge
//   res          in   asynchronous active-low reset
//   RX           in   serial line, idle high, asynchronous to clk
//   data_out     out  [7:0] last correctly framed byte (held until next one)
//   en_data_out  out  one-clock pulse: data_out has just been updated
//   frame_err    out  one-clock pulse: stop bit sampled as 0
//   rdy          out  1 while a frame is in progress, 0 when idle
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 5000,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       res,
  input  logic       RX,
  output logic [7:0] data_out,
  output logic       en_data_out,
  output logic       frame_err,
  output logic       rdy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Two-flop synchroniser plus one delayed copy for edge detection; the
  // line idles high, so these reset to 1 to avoid a false start edge.
  logic             sync1_q;
  logic             rx_s_q;
  logic             rx_prev_q;

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q,   shreg_d;
  logic [7:0]       data_q,    data_d;
  logic             en_q,      en_d;
  logic             err_q,     err_d;
  logic             rdy_q,     rdy_d;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= RX;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      en_q      <= en_d;
      err_q     <= err_d;
      rdy_q     <= rdy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    en_d      = 1'b0;
    err_d     = 1'b0;
    rdy_d     = rdy_q;

    case (state_q)
      IDLE: begin
        rdy_d = 1'b0;
        // Edge, not level: a line held low (break) must not re-arm.
        if (rx_prev_q && !rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
          rdy_d   = 1'b1;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            // Low pulse shorter than half a bit: treat as a glitch.
            state_d = IDLE;
            rdy_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shreg_d   = {rx_s_q, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          // Leaving at mid-stop gives half a bit of margin to catch the
          // next start edge when frames arrive back to back.
          cnt_d   = '0;
          state_d = IDLE;
          rdy_d   = 1'b0;
          if (rx_s_q) begin
            data_d = shreg_q;
            en_d   = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  assign data_out    = data_q;
  assign en_data_out = en_q;
  assign frame_err   = err_q;
  assign rdy         = rdy_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx at 16 clocks per bit.
//
// Cycle 0 is the cycle in which the bench drives the start bit low. RX goes
// through two synchroniser flops, so rx_s falls at cycle 2 (T = 2). The start
// check is at T+HALF, the stop sample at T+HALF+9*CPB, and the strobe shows
// one cycle later: cycle 3+HALF+9*CPB. rdy is high from cycle 3 up to the
// cycle before the strobe.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB       = 16;
  localparam int HALF      = CPB / 2;
  localparam int PULSE_CYC = 3 + HALF + 9 * CPB;
  localparam int HIST_N    = 1024;

  logic       clk;
  logic       res;
  logic       RX;
  logic [7:0] data_out;
  logic       en_data_out;
  logic       frame_err;
  logic       rdy;

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk         (clk),
    .res         (res),
    .RX          (RX),
    .data_out    (data_out),
    .en_data_out (en_data_out),
    .frame_err   (frame_err),
    .rdy         (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         idle_after;
    logic       good;
  } frame_vec_t;

  int n_pass  = 0;
  int n_total = 0;

  int         cyc;
  longint     abs_cyc = 0;
  int         en_cnt, err_cnt, en_cyc, err_cyc;
  longint     en_abs;
  logic [7:0] en_data;
  logic       both_high;
  logic       rdy_seen;
  logic       rdy_hist [HIST_N];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic clear_mon();
    cyc       = 0;
    en_cnt    = 0;
    err_cnt   = 0;
    en_cyc    = -1;
    err_cyc   = -1;
    en_data   = 8'h00;
    both_high = 1'b0;
    rdy_seen  = 1'b0;
    for (int i = 0; i < HIST_N; i++) rdy_hist[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    abs_cyc++;
    if (cyc < HIST_N) rdy_hist[cyc] = rdy;
    if (rdy) rdy_seen = 1'b1;
    if (en_data_out) begin
      en_cnt++;
      en_cyc  = cyc;
      en_abs  = abs_cyc;
      en_data = data_out;
    end
    if (frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (en_data_out && frame_err) both_high = 1'b1;
  endtask

  task automatic drive(input logic v, input int n);
    RX = v;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    clear_mon();
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(stop, CPB);
  endtask

  function automatic logic rdy_window_ok();
    logic ok;
    ok = !rdy_hist[2] && !rdy_hist[PULSE_CYC];
    for (int i = 3; i < PULSE_CYC; i++) if (!rdy_hist[i]) ok = 1'b0;
    return ok;
  endfunction

  frame_vec_t vecs [7];
  logic [7:0] exp_last;
  longint     prev_en_abs;

  initial begin
    vecs[0] = '{data: 8'h53, stop: 1'b1, idle_after: 5, good: 1'b1};
    vecs[1] = '{data: 8'hA5, stop: 1'b1, idle_after: 0, good: 1'b1};
    vecs[2] = '{data: 8'h00, stop: 1'b1, idle_after: 5, good: 1'b1};
    vecs[3] = '{data: 8'h55, stop: 1'b1, idle_after: 0, good: 1'b1};
    vecs[4] = '{data: 8'hAA, stop: 1'b1, idle_after: 0, good: 1'b1};
    vecs[5] = '{data: 8'hFF, stop: 1'b1, idle_after: 5, good: 1'b1};
    vecs[6] = '{data: 8'h3C, stop: 1'b0, idle_after: 0, good: 1'b0};

    RX  = 1'b1;
    res = 1'b0;
    #17;
    check("reset data_out", data_out, 8'h00);
    check("reset en_data_out", en_data_out, 0);
    check("reset frame_err", frame_err, 0);
    check("reset rdy", rdy, 0);
    res = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    drive(1'b1, 6);

    exp_last    = 8'h00;
    prev_en_abs = -1;
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].data, vecs[v].stop);
      if (vecs[v].good) exp_last = vecs[v].data;
      check($sformatf("v%0d en count", v), en_cnt, vecs[v].good ? 1 : 0);
      check($sformatf("v%0d err count", v), err_cnt, vecs[v].good ? 0 : 1);
      check($sformatf("v%0d pulse cycle", v),
            vecs[v].good ? en_cyc : err_cyc, PULSE_CYC);
      check($sformatf("v%0d data_out", v), data_out, exp_last);
      check($sformatf("v%0d rdy window", v), rdy_window_ok(), 1);
      check($sformatf("v%0d en/err overlap", v), both_high, 0);
      if (v == 2) check("back-to-back pulse gap", en_abs - prev_en_abs, 10 * CPB);
      if (vecs[v].good) prev_en_abs = en_abs;
      if (vecs[v].idle_after > 0) drive(1'b1, vecs[v].idle_after);
    end

    // Line left low after the bad stop bit: must not retrigger.
    clear_mon();
    drive(1'b0, 20 * CPB);
    check("break en count", en_cnt, 0);
    check("break err count", err_cnt, 0);
    check("break rdy stays low", rdy_seen, 0);
    check("break data_out held", data_out, exp_last);
    drive(1'b1, 8);
    send_frame(8'h0F, 1'b1);
    exp_last = 8'h0F;
    check("after break en count", en_cnt, 1);
    check("after break pulse cycle", en_cyc, PULSE_CYC);
    check("after break data_out", data_out, exp_last);
    drive(1'b1, 4);

    // Short low glitch: start check at cycle 10 fails, rdy drops at 11.
    clear_mon();
    drive(1'b0, HALF / 2);
    drive(1'b1, 5 * CPB);
    check("glitch rdy at check", rdy_hist[2 + HALF], 1);
    check("glitch rdy after check", rdy_hist[3 + HALF], 0);
    check("glitch en count", en_cnt, 0);
    check("glitch err count", err_cnt, 0);
    check("glitch data_out held", data_out, exp_last);

    // Reset in the middle of bit 4 of a 0xFF frame.
    clear_mon();
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(1'b1, CPB);
    drive(1'b1, HALF);
    check("pre-reset rdy", rdy, 1);
    res = 1'b0;
    #2;
    check("mid-frame reset data_out", data_out, 8'h00);
    check("mid-frame reset rdy", rdy, 0);
    check("mid-frame reset en/err", {en_data_out, frame_err}, 2'b00);
    repeat (3) tick();
    res = 1'b1;
    clear_mon();
    drive(1'b1, 4 * CPB);
    check("post-reset no pulse", en_cnt + err_cnt, 0);
    send_frame(8'h81, 1'b1);
    check("post-reset en count", en_cnt, 1);
    check("post-reset pulse cycle", en_cyc, PULSE_CYC);
    check("post-reset data_out", data_out, 8'h81);
    check("post-reset strobe data", en_data, 8'h81);
    drive(1'b1, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
